// File: rtl/data_memory_responder_if.sv
// Valid/ready request and response channels between the MEM stage (master)
// and the data-memory responder (slave).
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle little-endian byte-array data memory with a fixed response latency.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range accesses on resp_err instead of wrapping.
module data_memory_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned LATENCY     = 4
) (
    input logic                     clk,
    input logic                     rst,
    data_memory_responder_if.slave  mem_if
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_BYTES);
    localparam int unsigned WORD_W = IDX_W - 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                oor_q, oor_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                mem_we;

    logic [7:0]          mem_q [DEPTH_BYTES];
    logic [31:0]         offset;
    logic [31:0]         rd_word;
    logic                req_oor;
    logic                unused_bits;

    assign offset      = mem_if.req_addr - BASE_ADDR;
    assign unused_bits = ^{offset[31:IDX_W], offset[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
    // Offset is compared with its low bits cleared so a word straddling the top is rejected.
    assign req_oor = (mem_if.req_addr < BASE_ADDR) ||
                     ({offset[31:2], 2'b00} >= 32'(DEPTH_BYTES));
    assign mem_if.resp_err = err_q;
`else
    logic unused_err;
    assign req_oor         = 1'b0;
    assign unused_err      = err_q;
    assign mem_if.resp_err = 1'b0;
`endif

    assign rd_word = {mem_q[{word_q, 2'd3}], mem_q[{word_q, 2'd2}],
                      mem_q[{word_q, 2'd1}], mem_q[{word_q, 2'd0}]};

    assign mem_if.req_ready  = (state_q == IDLE);
    assign mem_if.resp_valid = (state_q == RESP);
    assign mem_if.resp_rdata = rdata_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latches are inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_if.req_valid) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    we_d    = mem_if.req_we;
                    word_d  = offset[IDX_W-1:2];
                    wdata_d = mem_if.req_wdata;
                    oor_d   = req_oor;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = oor_q;
                    mem_we  = we_q && !oor_q;
                    rdata_d = (we_q || oor_q) ? 32'd0 : rd_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (mem_if.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array has no reset; its contents survive rst by design.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[{word_q, 2'd0}] <= wdata_q[7:0];
            mem_q[{word_q, 2'd1}] <= wdata_q[15:8];
            mem_q[{word_q, 2'd2}] <= wdata_q[23:16];
            mem_q[{word_q, 2'd3}] <= wdata_q[31:24];
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a LATENCY=4 and a LATENCY=1 instance.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel1 = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_ready = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_memory_responder_if if4 ();
    data_memory_responder_if if1 ();

    assign if4.req_valid  = req_valid & ~sel1;
    assign if4.req_we     = req_we;
    assign if4.req_addr   = req_addr;
    assign if4.req_wdata  = req_wdata;
    assign if4.resp_ready = resp_ready & ~sel1;
    assign if1.req_valid  = req_valid & sel1;
    assign if1.req_we     = req_we;
    assign if1.req_addr   = req_addr;
    assign if1.req_wdata  = req_wdata;
    assign if1.resp_ready = resp_ready & sel1;

    logic        rdy, rv, err;
    logic [31:0] rdata;
    assign rdy   = sel1 ? if1.req_ready  : if4.req_ready;
    assign rv    = sel1 ? if1.resp_valid : if4.resp_valid;
    assign rdata = sel1 ? if1.resp_rdata : if4.resp_rdata;
    assign err   = sel1 ? if1.resp_err   : if4.resp_err;

    data_memory_responder #(.BASE_ADDR(32'd1024), .DEPTH_BYTES(256), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .mem_if(if4.slave)
    );
    data_memory_responder #(.BASE_ADDR(32'd1024), .DEPTH_BYTES(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_if(if1.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        check({tag, "_req_ready"}, 32'(rdy), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat,
                             input logic [31:0] exp_rdata, input logic exp_err);
        int lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!rv && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check({tag, "_valid_cleared"}, 32'(rv), 32'd0);
        check({tag, "_ready_back"}, 32'(rdy), 32'd1);
    endtask

    task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int exp_lat,
                            input logic [31:0] exp_rdata, input logic exp_err);
        send(tag, we, addr, wdata);
        wait_resp(tag, exp_lat, exp_rdata, exp_err);
        handshake(tag);
    endtask

    initial begin
        // Reset state of both instances
        repeat (2) @(negedge clk);
        check("rst4_req_ready", 32'(if4.req_ready), 32'd1);
        check("rst4_resp_valid", 32'(if4.resp_valid), 32'd0);
        check("rst4_rdata", if4.resp_rdata, 32'd0);
        check("rst4_err", 32'(if4.resp_err), 32'd0);
        check("rst1_req_ready", 32'(if1.req_ready), 32'd1);
        check("rst1_resp_valid", 32'(if1.resp_valid), 32'd0);
        rst = 1'b0;

        // Store then loads, LATENCY=4
        transact("st1024", 1'b1, 32'd1024, 32'hDEADBEEF, 4, 32'd0, 1'b0);
        transact("ld1024", 1'b0, 32'd1024, 32'd0, 4, 32'hDEADBEEF, 1'b0);
        transact("ld1026", 1'b0, 32'd1026, 32'd0, 4, 32'hDEADBEEF, 1'b0);

        // Backpressure: response held, competing store ignored
        send("bp", 1'b0, 32'd1024, 32'd0);
        wait_resp("bp", 4, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'd1024; req_wdata = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(rv), 32'd1);
            check("bp_hold_rdata", rdata, 32'hDEADBEEF);
            check("bp_hold_req_ready", 32'(rdy), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        handshake("bp");
        transact("bp_after", 1'b0, 32'd1024, 32'd0, 4, 32'hDEADBEEF, 1'b0);

        // Reset two cycles into a store drops it
        transact("st1028", 1'b1, 32'd1028, 32'h11112222, 4, 32'd0, 1'b0);
        send("rstbusy", 1'b1, 32'd1028, 32'h12345678);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstbusy_req_ready", 32'(rdy), 32'd1);
        check("rstbusy_resp_valid", 32'(rv), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        transact("ld1028", 1'b0, 32'd1028, 32'd0, 4, 32'h11112222, 1'b0);

        // Wrap / range check at BASE_ADDR+DEPTH_BYTES
`ifdef DMEM_RANGE_CHECK_EN
        transact("st1280", 1'b1, 32'd1280, 32'hCAFEF00D, 4, 32'd0, 1'b1);
        transact("wrap_ld1024", 1'b0, 32'd1024, 32'd0, 4, 32'hDEADBEEF, 1'b0);
        transact("ld1020", 1'b0, 32'd1020, 32'd0, 4, 32'd0, 1'b1);
`else
        transact("st1280", 1'b1, 32'd1280, 32'hCAFEF00D, 4, 32'd0, 1'b0);
        transact("wrap_ld1024", 1'b0, 32'd1024, 32'd0, 4, 32'hCAFEF00D, 1'b0);
`endif

        // LATENCY=1 instance: store immediately followed by load
        sel1 = 1'b1;
        transact("l1_st1040", 1'b1, 32'd1040, 32'hA5A55A5A, 1, 32'd0, 1'b0);
        transact("l1_ld1040", 1'b0, 32'd1040, 32'd0, 1, 32'hA5A55A5A, 1'b0);
        transact("l1_st1040b", 1'b1, 32'd1040, 32'h0BADF00D, 1, 32'd0, 1'b0);
        transact("l1_ld1043", 1'b0, 32'd1043, 32'd0, 1, 32'h0BADF00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Multi-cycle data-memory target answering load/store requests issued by the MEM stage.
- Replaces the zero-latency array so the pipeline can be exercised against a memory that stalls.
- Request and response channels use valid/ready handshakes.
- Byte-array storage is little-endian and word-aligned, mapped at BASE_ADDR.

Parameters:
- BASE_ADDR, 1024: byte address mapped to array byte 0.
- DEPTH_BYTES, 256: array size in bytes; power of two, multiple of 4.
- LATENCY, 4: cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address, same value as the ALU result.
- req_wdata  input  32  store data (Rm value).
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for a store response.
- resp_err  output  1  address out of range; only driven when the optional feature is compiled in.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - Array contents are not reset.
- FSM IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/addr/wdata, load counter=LATENCY-1, go BUSY.
- FSM BUSY:
  - req_ready=0. Counter decrements each cycle.
  - When counter==0:
    - Store: write the array in that cycle.
    - Load: read the array into resp_rdata in that cycle.
    - Go RESP next edge.
- FSM RESP:
  - resp_valid=1; resp_rdata and resp_err held stable.
  - On resp_ready, clear resp_valid and return to IDLE.
- Latency: a request accepted at edge N gives resp_valid=1 after edge N+LATENCY.
- Back-to-back requests: the next request is accepted at the earliest in the cycle after the response handshake, because req_ready is 0 throughout BUSY and RESP. No request overlap.
- req_ready depends only on state, never combinationally on req_valid.
- Address mapping:
  - offset = req_addr - BASE_ADDR, 32-bit wrap.
  - aligned = {offset[31:2],2'b00}.
  - index = aligned mod DEPTH_BYTES.
  - Low 2 address bits are ignored.
- Byte order: byte index holds data[7:0], index+1 holds [15:8], index+2 holds [23:16], index+3 holds [31:24].
- Ordering: a store commits before its response, so a following load to the same address returns the new data.
- resp_ready held high while in RESP: the response lasts exactly 1 cycle.
- resp_ready held low: the response is held indefinitely and no new request is accepted.
- Reset during BUSY: a pending store is dropped if its counter had not reached 0. The FSM returns to IDLE.
- Reset during RESP: the response is discarded.
- req_valid while not IDLE: ignored, not latched. The initiator must hold the request until req_ready.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined:
  - A request whose req_addr < BASE_ADDR, or whose aligned word is not fully below BASE_ADDR+DEPTH_BYTES, is out of range.
  - For an out-of-range request: the store is suppressed, load resp_rdata=0, resp_err=1 with the response.
  - Latency is unchanged.
- Undefined:
  - No range test; the address wraps modulo DEPTH_BYTES.
  - resp_err tied to 0.

Test Plan:
- Reset then idle: after rst pulse -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Store then load, LATENCY=4:
  - Store addr 1024, data 0xDEADBEEF -> resp_valid exactly 4 cycles after acceptance.
  - Load addr 1024 -> resp_rdata=0xDEADBEEF.
  - Load addr 1026 -> 0xDEADBEEF (alignment).
- Backpressure: load with resp_ready=0 for 5 cycles -> resp_valid and data stable; req_ready=0 and a second req_valid is ignored until the handshake.
- Reset mid-BUSY: store 0x12345678 to 1028, assert rst 2 cycles after acceptance -> a later load of 1028 returns the prior contents, not 0x12345678.
- Wrap/range:
  - Store 0xCAFEF00D to addr 1024+256.
  - Without the macro: a load of 1024 returns 0xCAFEF00D.
  - With DMEM_RANGE_CHECK_EN: resp_err=1, the array is unchanged, and a load of 1020 returns resp_err=1, rdata=0.
- LATENCY=1: a request accepted at edge N gives resp_valid after edge N+1; a store followed immediately by a load of the same address returns the new data.
